// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Main control FSM for the multicycle 16-bit processor. It decodes the 4-bit
//   opcode of the latched instruction and sequences the instruction through
//   fetch, decode, execute, memory and writeback. In every state it drives the
//   datapath mux selects, the write enables and the 2-bit ALUOp for the ALU
//   control decoder. Memory accesses use a req/ready handshake. A wait counter
//   turns a stalled access into a terminal ERROR state.
//
//   Parameters:
//     MEM_TIMEOUT  maximum number of cycles a memory state waits for mem_ready
//                  before the FSM enters ERROR (1..255)
//
//   Ports:
//     clock, reset         rising-edge clock; asynchronous active-low reset
//     opcode               instr[15:12] from the instruction register
//     zero                 ALU zero flag. The datapath uses it to qualify
//                          PCWriteCond; the FSM itself ignores it.
//     mem_ready            memory completes the current access this cycle
//     ALUOp .. MemtoReg    datapath controls (Moore, decoded from the state)
//     state                current state code, for debug
//     instr_done           1-cycle pulse when an instruction retires
//     illegal_op           1-cycle pulse in DECODE on an unsupported opcode
//     halted               high in HALT or ERROR
//     mem_error            sticky flag, set on a memory timeout
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       halted,
  output logic       mem_error
);

  typedef enum logic [3:0] {
    S_RST     = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADDR = 4'd3,
    S_MEMRD   = 4'd4,
    S_LWWB    = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXR     = 4'd7,
    S_RWB     = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_EXI     = 4'd11,
    S_IWB     = 4'd12,
    S_HALT    = 4'd13,
    S_ERROR   = 4'd14
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt;
  logic       mem_error_q;
  logic       in_mem_state;
  logic       timeout;
  logic       legal_op;

  // The branch decision happens in the datapath, so the FSM never reads zero.
  logic unused_zero;
  assign unused_zero = zero;

  assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) ||
                        (state_q == S_MEMWR);
  // A ready arriving in the same cycle the count reaches the limit still wins.
  assign timeout  = in_mem_state && !mem_ready && (wait_cnt == TIMEOUT);
  assign legal_op = (opcode <= 4'd5) || (opcode == 4'hf);

  // Next-state logic.
  // NOTE: every variable written in an always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RST:     state_d = S_FETCH;
      S_FETCH:   state_d = mem_ready ? S_DECODE : (timeout ? S_ERROR : S_FETCH);
      S_DECODE: begin
        case (opcode)
          4'b0000:          state_d = S_EXR;
          4'b0001, 4'b0010: state_d = S_MEMADDR;
          4'b0011:          state_d = S_BRANCH;
          4'b0100:          state_d = S_JUMP;
          4'b0101:          state_d = S_EXI;
          4'b1111:          state_d = S_HALT;
          default:          state_d = S_FETCH;
        endcase
      end
      // The IR is stable here, so the opcode is simply looked at again.
      S_MEMADDR: state_d = (opcode == 4'b0001) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   state_d = mem_ready ? S_LWWB : (timeout ? S_ERROR : S_MEMRD);
      S_LWWB:    state_d = S_FETCH;
      S_MEMWR:   state_d = mem_ready ? S_FETCH : (timeout ? S_ERROR : S_MEMWR);
      S_EXR:     state_d = S_RWB;
      S_RWB:     state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      S_EXI:     state_d = S_IWB;
      S_IWB:     state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      S_ERROR:   state_d = S_ERROR;
      default:   state_d = S_ERROR;
    endcase
  end

  // State, wait counter and sticky error flag.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // sees the values from before the clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_RST;
      wait_cnt    <= 8'd0;
      mem_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Clear the counter on entry to a memory state. Otherwise count each cycle
      // the FSM stays in the state without mem_ready.
      if ((state_d != state_q) &&
          ((state_d == S_FETCH) || (state_d == S_MEMRD) || (state_d == S_MEMWR)))
        wait_cnt <= 8'd0;
      else if (in_mem_state && !mem_ready && (state_d == state_q))
        wait_cnt <= wait_cnt + 8'd1;
      if (timeout)
        mem_error_q <= 1'b1;
    end
  end

  // Moore output decode. Only the FETCH IR/PC loads, the MEMWR retire pulse and
  // the DECODE illegal-opcode pulse also look at the inputs.
  always_comb begin
    ALUOp       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 2'b00;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB    = 2'b11;
        illegal_op = !legal_op;
      end
      S_MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_LWWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      S_EXR: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        instr_done = 1'b1;
      end
      S_EXI: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
      end
      S_IWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      S_ERROR: halted = 1'b1;
      default: ;
    endcase
  end

  assign state     = state_q;
  assign mem_error = mem_error_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multicycle 16-bit processor. It decodes the 4-bit opcode of the latched instruction and sequences fetch/decode/execute/memory/writeback. Each cycle it drives the datapath mux selects, write enables and the 2-bit ALUOp consumed by the ALU control decoder. Memory accesses use a req/ready handshake with a timeout, and the block reports retired instructions, illegal opcodes and halt.

Parameters:
MEM_TIMEOUT, 15, max cycles a memory state waits for mem_ready before entering ERROR (range 1..255)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
opcode  input  4  instr[15:12] from the instruction register
zero  input  1  ALU zero flag (branch compare)
mem_ready  input  1  memory completes the current access this cycle
ALUOp  output  2  00 add (LW/SW/PC), 01 sub (BEQ), 10 funct (R-type), 11 add (ADDI)
ALUSrcA  output  1  0=PC, 1=regA
ALUSrcB  output  2  00=regB, 01=const 1, 10=sign-ext imm, 11=sign-ext branch offset
IorD  output  1  0=PC address, 1=ALUOut address
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  load instruction register
PCWrite  output  1  unconditional PC load
PCWriteCond  output  1  PC load if zero
PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target
RegWrite  output  1  register file write enable
RegDst  output  1  0=rt, 1=rd
MemtoReg  output  1  0=ALUOut, 1=MDR
state  output  4  current state code (debug)
instr_done  output  1  1-cycle pulse when an instruction retires
illegal_op  output  1  1-cycle pulse on unsupported opcode
halted  output  1  high in HALT or ERROR
mem_error  output  1  sticky; set on memory timeout

Behaviour:
- Moore FSM. Outputs decode from state; exceptions are IRWrite/PCWrite in FETCH, which are gated by mem_ready. Every output not listed for a state is 0.
- State codes: RST=0, FETCH=1, DECODE=2, MEMADDR=3, MEMRD=4, LWWB=5, MEMWR=6, EXR=7, RWB=8, BRANCH=9, JUMP=10, EXI=11, IWB=12, HALT=13, ERROR=14.
- Reset low: state=RST, wait counter=0, mem_error=0. All outputs are 0, including state=0. RST always advances to FETCH on the next edge.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=mem_ready. Stays until mem_ready, then goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Dispatch on opcode:
  - 0000 -> EXR
  - 0001/0010 -> MEMADDR
  - 0011 -> BRANCH
  - 0100 -> JUMP
  - 0101 -> EXI
  - 1111 -> HALT
  - any other -> FETCH, with illegal_op pulsed for this cycle.
- EXR: ALUSrcA=1, ALUSrcB=00, ALUOp=10, -> RWB.
- RWB: RegDst=1, RegWrite=1, MemtoReg=0, instr_done=1, -> FETCH.
- MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD if the opcode is 0001, else MEMWR. Opcode is sampled again here; the IR is stable.
- MEMRD: MemRead=1, IorD=1. Goes to LWWB on mem_ready.
- LWWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1, -> FETCH.
- MEMWR: MemWrite=1, IorD=1. On mem_ready: instr_done=1, -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1, -> FETCH. The zero input only qualifies the PC load in the datapath; the state path does not depend on it.
- JUMP: PCWrite=1, PCSource=10, instr_done=1, -> FETCH.
- EXI: ALUSrcA=1, ALUSrcB=10, ALUOp=11, -> IWB.
- IWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1, -> FETCH.
- HALT: halted=1, terminal until reset. No memory requests.
- Wait counter (8 bits):
  - Cleared on entry to FETCH, MEMRD and MEMWR.
  - Increments each cycle the block stays in such a state without mem_ready.
  - If the counter equals MEM_TIMEOUT with mem_ready still low: next state is ERROR and mem_error is set.
  - mem_ready in the same cycle as the count reaching MEM_TIMEOUT: the transfer completes normally, with no error.
- ERROR: halted=1, mem_error=1, all requests 0. Terminal until reset.
- mem_ready outside memory states is ignored.
- Reset asserted mid-instruction aborts the instruction immediately, with no partial writes after the edge.

Test Plan:
- Reset released, mem_ready=1 constantly, opcode=0000 -> states 0,1,2,7,8,1. In state 7, ALUOp=10. In state 8, RegWrite=1 and RegDst=1, and instr_done pulses once.
- LW (0001) with mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles with MemRead=1 and IorD=1. Then LWWB with MemtoReg=1 and RegWrite=1.
- SW (0010) -> MEMWR with MemWrite=1. RegWrite stays 0 throughout, and instr_done pulses in the cycle mem_ready=1.
- BEQ (0011) -> BRANCH with ALUOp=01, PCWriteCond=1, PCSource=01. JUMP (0100) -> PCWrite=1, PCSource=10. ADDI (0101) -> EXI with ALUOp=11, then IWB with RegDst=0.
- Opcode 0111 -> illegal_op pulses in DECODE, then FETCH. Opcode 1111 -> HALT, halted=1, and MemRead stays 0 for 20 cycles.
- MEM_TIMEOUT=3, mem_ready stuck 0 in FETCH -> ERROR after 4 FETCH cycles, with mem_error=1 and halted=1. Reset pulse -> state=0 and mem_error=0.
